// File: rtl/onehot_index_serializer.sv
// Serializes a multi-hot vector into one binary bit index per beat (all-zero vector -> one out_nz=0 beat).
// Latency: first beat valid the cycle after in_vec is accepted; one beat per cycle, no bubble between vectors.
// Backpressure: out_ready low holds the beat stable; in_ready also rises combinationally on an accepted last beat.
module onehot_index_serializer #(
    parameter int WIDTH     = 7,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_nz,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             zero_q, zero_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_last;
    logic             scan;
    logic             beat_hs;
    logic             load;

    // Later loop iterations override earlier ones, so the scan direction selects the winning end.
    always_comb begin
        pick_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (mask_q[i]) pick_idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (mask_q[i]) pick_idx = IDX_W'(i);
            end
        end
    end

    assign pick_last = ((mask_q & (mask_q - ONE)) == '0);

    // Outputs are forced idle while reset is held so a dropped vector never leaks a beat.
    assign scan      = (state_q == SCAN) && rst_n;
    assign out_valid = scan;
    assign out_idx   = scan ? pick_idx : '0;
    assign out_nz    = scan & ~zero_q;
    assign out_last  = scan & pick_last;

    assign beat_hs  = out_valid & out_ready;
    assign in_ready = rst_n & ((state_q == IDLE) | (beat_hs & out_last));
    assign load     = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        zero_d  = zero_q;
        if (beat_hs) begin
            mask_d = mask_q & ~(ONE << pick_idx);
            if (out_last) state_d = IDLE;
        end
        if (load) begin
            mask_d  = in_vec;
            zero_d  = (in_vec == '0);
            state_d = SCAN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_onehot_index_serializer.sv
// Directed bench: LSB-first and MSB-first instances, stalls, back-to-back vectors, zero vector, mid-scan reset.
module tb_onehot_index_serializer;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [6:0] a_in_vec, b_in_vec;
    logic       a_in_valid, b_in_valid;
    logic       a_in_ready, b_in_ready;
    logic [2:0] a_out_idx, b_out_idx;
    logic       a_out_nz, b_out_nz;
    logic       a_out_last, b_out_last;
    logic       a_out_valid, b_out_valid;
    logic       a_out_ready, b_out_ready;

    int         n_vec = 0;
    int         n_err = 0;
    logic [6:0] acc;

    always #5 clk = ~clk;

    onehot_index_serializer #(.WIDTH(7), .IDX_W(3), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n),
        .in_vec(a_in_vec), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_idx(a_out_idx), .out_nz(a_out_nz), .out_last(a_out_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    onehot_index_serializer #(.WIDTH(7), .IDX_W(3), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n),
        .in_vec(b_in_vec), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_idx(b_out_idx), .out_nz(b_out_nz), .out_last(b_out_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Packed as {valid, idx[2:0], nz, last}.
    task automatic beat_a(input string tag, input logic v, input logic [2:0] i,
                          input logic nz, input logic l);
        chk(tag, {26'd0, a_out_valid, a_out_idx, a_out_nz, a_out_last}, {26'd0, v, i, nz, l});
    endtask

    task automatic beat_b(input string tag, input logic v, input logic [2:0] i,
                          input logic nz, input logic l);
        chk(tag, {26'd0, b_out_valid, b_out_idx, b_out_nz, b_out_last}, {26'd0, v, i, nz, l});
    endtask

    task automatic cyc;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        a_in_vec    = '0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_in_vec    = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;

        // Reset held
        cyc; cyc;
        beat_a("rst_hold_out", 1'b0, 3'd0, 1'b0, 1'b0);
        chk("rst_hold_in_ready", a_in_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rst_rel_in_ready", a_in_ready, 1);
        beat_a("rst_rel_out", 1'b0, 3'd0, 1'b0, 1'b0);

        // 7'b0101001, LSB first
        a_in_vec = 7'b0101001; a_in_valid = 1'b1;
        cyc; a_in_valid = 1'b0;
        beat_a("v1_b0", 1'b1, 3'd0, 1'b1, 1'b0);
        chk("v1_b0_in_ready", a_in_ready, 0);
        cyc; beat_a("v1_b1", 1'b1, 3'd3, 1'b1, 1'b0);
        cyc; beat_a("v1_b2", 1'b1, 3'd5, 1'b1, 1'b1);
        chk("v1_b2_in_ready", a_in_ready, 1);
        cyc; beat_a("v1_idle", 1'b0, 3'd0, 1'b0, 1'b0);
        chk("v1_idle_in_ready", a_in_ready, 1);

        // All-zero vector
        a_in_vec = 7'b0000000; a_in_valid = 1'b1;
        cyc; a_in_valid = 1'b0;
        beat_a("zero_b0", 1'b1, 3'd0, 1'b0, 1'b1);
        chk("zero_in_ready", a_in_ready, 1);
        cyc; beat_a("zero_idle", 1'b0, 3'd0, 1'b0, 1'b0);
        chk("zero_idle_in_ready", a_in_ready, 1);

        // 7'b1100010 with out_ready 1,0,0,1,1
        a_in_vec = 7'b1100010; a_in_valid = 1'b1;
        cyc; a_in_valid = 1'b0; a_out_ready = 1'b1;
        beat_a("stall_b0", 1'b1, 3'd1, 1'b1, 1'b0);
        @(negedge clk) a_out_ready = 1'b0; #1;
        beat_a("stall_s1", 1'b1, 3'd5, 1'b1, 1'b0);
        cyc; beat_a("stall_s2", 1'b1, 3'd5, 1'b1, 1'b0);
        chk("stall_in_ready", a_in_ready, 0);
        @(negedge clk) a_out_ready = 1'b1; #1;
        beat_a("stall_b1", 1'b1, 3'd5, 1'b1, 1'b0);
        cyc; beat_a("stall_b2", 1'b1, 3'd6, 1'b1, 1'b1);
        cyc; beat_a("stall_idle", 1'b0, 3'd0, 1'b0, 1'b0);

        // Back-to-back 7'b1111111 then 7'b1000000
        a_in_vec = 7'b1111111; a_in_valid = 1'b1;
        cyc; a_in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            beat_a($sformatf("b2b_b%0d", i), 1'b1, 3'(i), 1'b1, 1'b0);
            cyc;
        end
        beat_a("b2b_b6", 1'b1, 3'd6, 1'b1, 1'b1);
        a_in_vec = 7'b1000000; a_in_valid = 1'b1; #1;
        chk("b2b_in_ready", a_in_ready, 1);
        cyc; a_in_valid = 1'b0;
        beat_a("b2b_b7", 1'b1, 3'd6, 1'b1, 1'b1);
        cyc; beat_a("b2b_idle", 1'b0, 3'd0, 1'b0, 1'b0);

        // MSB first, decode-and-OR reconstruction
        acc = '0;
        b_in_vec = 7'b0101001; b_in_valid = 1'b1;
        cyc; b_in_valid = 1'b0;
        beat_b("msb_b0", 1'b1, 3'd5, 1'b1, 1'b0);
        if (b_out_nz) acc = acc | (7'd1 << b_out_idx);
        cyc; beat_b("msb_b1", 1'b1, 3'd3, 1'b1, 1'b0);
        if (b_out_nz) acc = acc | (7'd1 << b_out_idx);
        cyc; beat_b("msb_b2", 1'b1, 3'd0, 1'b1, 1'b1);
        if (b_out_nz) acc = acc | (7'd1 << b_out_idx);
        chk("msb_or", acc, 7'b0101001);
        cyc; beat_b("msb_idle", 1'b0, 3'd0, 1'b0, 1'b0);

        // Reset mid-scan after first beat of 7'b1110000
        a_in_vec = 7'b1110000; a_in_valid = 1'b1;
        cyc; a_in_valid = 1'b0;
        beat_a("mrst_b0", 1'b1, 3'd4, 1'b1, 1'b0);
        @(negedge clk) rst_n = 1'b0; #1;
        beat_a("mrst_hold", 1'b0, 3'd0, 1'b0, 1'b0);
        chk("mrst_hold_in_ready", a_in_ready, 0);
        @(negedge clk) rst_n = 1'b1; #1;
        beat_a("mrst_rel", 1'b0, 3'd0, 1'b0, 1'b0);
        chk("mrst_rel_in_ready", a_in_ready, 1);
        cyc; beat_a("mrst_quiet1", 1'b0, 3'd0, 1'b0, 1'b0);
        cyc; beat_a("mrst_quiet2", 1'b0, 3'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
